// File: rtl/riscv_datapath_if.sv
// Bus between the RV32I datapath and its controller / memories.
// The master drives instruction, memory read data and control strobes;
// the slave (the datapath) returns PC, ALU and write-back results.
interface riscv_datapath_if;
    logic [31:0] instr;
    logic [31:0] dReadData;
    logic        loadPC;
    logic        PCSrc;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        RegWrite;
    logic        MemToReg;
    logic [31:0] PC;
    logic        Zero;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] WriteBackData;

    modport master (
        output instr, dReadData, loadPC, PCSrc, ALUSrc, ALUCtrl, RegWrite, MemToReg,
        input  PC, Zero, dAddress, dWriteData, WriteBackData
    );

    modport slave (
        input  instr, dReadData, loadPC, PCSrc, ALUSrc, ALUCtrl, RegWrite, MemToReg,
        output PC, Zero, dAddress, dWriteData, WriteBackData
    );
endinterface

// File: rtl/riscv_datapath.sv
// RV32I multicycle datapath core: PC, 32x32 register file, immediate
// generator, ALU and write-back mux. All sequencing comes from an external
// controller through the interface strobes.
module riscv_datapath #(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input logic              clk,
    input logic              rst,
    riscv_datapath_if.slave  bus
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];

    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm;
    logic [31:0] imm_b;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [31:0] wb_data;
    logic        unused_funct3;

    // The ALU is a pure function of operation and operands; any
    // unassigned code yields zero so the controller can park the ALU.
    function automatic logic [31:0] alu_op(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_AND: alu_op = a & b;
            ALU_OR:  alu_op = a | b;
            ALU_ADD: alu_op = a + b;
            ALU_SUB: alu_op = a - b;
            ALU_XOR: alu_op = a ^ b;
            ALU_SLT: alu_op = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SRL: alu_op = a >> sh;
            ALU_SLL: alu_op = a << sh;
            ALU_SRA: alu_op = $unsigned($signed(a) >>> sh);
            default: alu_op = 32'd0;
        endcase
    endfunction

    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign rd     = bus.instr[11:7];
    assign opcode = bus.instr[6:0];

    // funct3 is decoded by the controller, not here.
    assign unused_funct3 = ^bus.instr[14:12];

    // x0 is hardwired to zero on both read ports.
    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    // Branch offset is always formed from the B-type fields so the PC mux
    // does not depend on the immediate decoder.
    assign imm_b = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                    bus.instr[11:8], 1'b0};

    // Immediate generator: format chosen by opcode, zero for anything else.
    always_comb begin
        imm = 32'd0;
        case (opcode)
            OPC_OPIMM, OPC_LOAD: imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
            OPC_STORE:           imm = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            OPC_BRANCH:          imm = imm_b;
            default:             imm = 32'd0;
        endcase
    end

    assign alu_b   = bus.ALUSrc ? imm : rs2_data;
    assign alu_res = alu_op(bus.ALUCtrl, rs1_data, alu_b);
    assign wb_data = bus.MemToReg ? bus.dReadData : alu_res;

    assign bus.Zero          = (alu_res == 32'd0);
    assign bus.dAddress      = alu_res;
    assign bus.dWriteData    = rs2_data;
    assign bus.WriteBackData = wb_data;
    assign bus.PC            = pc_q;

    // Next PC: sequential or branch target, both relative to the current PC.
    always_comb begin
        pc_d = pc_q;
        if (bus.loadPC) begin
            pc_d = bus.PCSrc ? (pc_q + imm_b) : (pc_q + 32'd4);
        end
    end

    // PC register; reset wins over any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= INITIAL_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Register file write port; reset clears every entry and suppresses
    // any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (bus.RegWrite && (rd != 5'd0)) begin
            rf_q[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_riscv_datapath.sv
// Self-checking bench for riscv_datapath: directed scenarios from the
// bring-up sequence followed by randomized instructions against a
// behavioural register-file / PC model.
module tb_riscv_datapath;

    logic clk;
    logic rst;
    riscv_datapath_if bus ();

    riscv_datapath #(.INITIAL_PC(32'h00400000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_pc;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rd(input logic [4:0] r);
        return (r == 0) ? 32'd0 : m_rf[r];
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] sign;
        sign = 32'd1 << (bits - 1);
        return (v ^ sign) - sign;
    endfunction

    function automatic logic [31:0] m_immb(input logic [31:0] ins);
        logic [31:0] raw;
        raw = ({31'd0, ins[31]} << 12) + ({31'd0, ins[7]} << 11) +
              ({26'd0, ins[30:25]} << 5) + ({28'd0, ins[11:8]} << 1);
        return sext(raw, 13);
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h13, 7'h03: return sext({20'd0, ins[31:20]}, 12);
            7'h23:        return sext({20'd0, ins[31:25], ins[11:7]}, 12);
            7'h63:        return m_immb(ins);
            default:      return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a + (~b + 1);
            4'h5: return a ^ b;
            4'h4: return ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
            4'h8: return a / (32'd1 << sh);
            4'h9: return a * (32'd1 << sh);
            4'hA: return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu_now();
        logic [31:0] b;
        b = bus.ALUSrc ? m_imm(bus.instr) : m_rd(bus.instr[24:20]);
        return m_alu(bus.ALUCtrl, m_rd(bus.instr[19:15]), b);
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, 3'b000, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic idle();
        bus.loadPC = 0; bus.PCSrc = 0; bus.ALUSrc = 0; bus.ALUCtrl = 4'h0;
        bus.RegWrite = 0; bus.MemToReg = 0; bus.dReadData = 32'd0; bus.instr = 32'd0;
    endtask

    // One clock edge; the model commits the same state change.
    task automatic step();
        logic [31:0] wb, npc;
        logic        we;
        logic [4:0]  rdn;
        wb  = bus.MemToReg ? bus.dReadData : m_alu_now();
        we  = bus.RegWrite;
        rdn = bus.instr[11:7];
        npc = bus.loadPC ? (bus.PCSrc ? m_pc + m_immb(bus.instr) : m_pc + 4) : m_pc;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_pc = 32'h00400000;
        end else begin
            if (we && rdn != 0) m_rf[rdn] = wb;
            m_pc = npc;
        end
    endtask

    // Presents "rs1 + 0" so dAddress shows the register contents.
    task automatic show_reg(input logic [4:0] r);
        idle();
        bus.instr = enc_r(5'd0, r, 5'd0);
        bus.ALUSrc = 1; bus.ALUCtrl = 4'h2;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        vecs++;
        if (bus.PC !== 32'h00400000) begin
            errs++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, 32'h00400000);
        end
        for (int r = 0; r < 32; r++) begin
            show_reg(r[4:0]);
            vecs++;
            if (bus.dAddress !== 32'd0) begin
                errs++; $display("FAIL reset_x%0d got=%h exp=0", r, bus.dAddress);
            end
        end
    endtask

    task automatic test_addi();
        idle();
        bus.instr = 32'h00500093; bus.ALUSrc = 1; bus.ALUCtrl = 4'h2; bus.RegWrite = 1;
        #1;
        vecs++;
        if (bus.WriteBackData !== 32'd5) begin
            errs++; $display("FAIL addi_wb got=%h exp=%h", bus.WriteBackData, 32'd5);
        end
        step();
        show_reg(5'd1);
        vecs++;
        if (bus.dAddress !== 32'd5) begin
            errs++; $display("FAIL addi_x1 got=%h exp=%h", bus.dAddress, 32'd5);
        end
    endtask

    task automatic test_sw_sub_sra();
        idle();
        bus.instr = 32'h00102423; bus.ALUSrc = 1; bus.ALUCtrl = 4'h2;
        #1;
        vecs++;
        if (bus.dAddress !== 32'd8) begin
            errs++; $display("FAIL sw_addr got=%h exp=%h", bus.dAddress, 32'd8);
        end
        vecs++;
        if (bus.dWriteData !== 32'd5) begin
            errs++; $display("FAIL sw_wdata got=%h exp=%h", bus.dWriteData, 32'd5);
        end
        // addi x2, x0, -16
        idle();
        bus.instr = enc_i(12'hFF0, 5'd0, 5'd2, 7'b0010011); bus.ALUSrc = 1; bus.ALUCtrl = 4'h2; bus.RegWrite = 1;
        step();
        idle();
        bus.instr = enc_r(5'd1, 5'd2, 5'd0); bus.ALUCtrl = 4'h6;
        #1;
        vecs++;
        if (bus.dAddress !== 32'hFFFFFFEB) begin
            errs++; $display("FAIL sub got=%h exp=%h", bus.dAddress, 32'hFFFFFFEB);
        end
        idle();
        bus.instr = 32'h40215013; bus.ALUSrc = 1; bus.ALUCtrl = 4'hA;
        #1;
        vecs++;
        if (bus.dAddress !== 32'hFFFFFFFC) begin
            errs++; $display("FAIL sra got=%h exp=%h", bus.dAddress, 32'hFFFFFFFC);
        end
    endtask

    task automatic test_load();
        idle();
        bus.instr = 32'h00002183; bus.ALUSrc = 1; bus.ALUCtrl = 4'h2;
        bus.MemToReg = 1; bus.RegWrite = 1; bus.dReadData = 32'hDEADBEEF;
        #1;
        vecs++;
        if (bus.WriteBackData !== 32'hDEADBEEF) begin
            errs++; $display("FAIL load_wb got=%h exp=%h", bus.WriteBackData, 32'hDEADBEEF);
        end
        step();
        show_reg(5'd3);
        vecs++;
        if (bus.dAddress !== 32'hDEADBEEF) begin
            errs++; $display("FAIL load_x3 got=%h exp=%h", bus.dAddress, 32'hDEADBEEF);
        end
    endtask

    task automatic test_branch();
        idle();
        bus.instr = 32'h00000463; bus.ALUCtrl = 4'h6;
        #1;
        vecs++;
        if (bus.Zero !== 1'b1) begin
            errs++; $display("FAIL beq_zero got=%b exp=1", bus.Zero);
        end
        bus.PCSrc = 1; bus.loadPC = 1;
        step();
        vecs++;
        if (bus.PC !== 32'h00400008) begin
            errs++; $display("FAIL beq_taken got=%h exp=%h", bus.PC, 32'h00400008);
        end
        bus.PCSrc = 0;
        step();
        vecs++;
        if (bus.PC !== 32'h0040000C) begin
            errs++; $display("FAIL pc_plus4 got=%h exp=%h", bus.PC, 32'h0040000C);
        end
        bus.PCSrc = 1; bus.loadPC = 0;
        step();
        vecs++;
        if (bus.PC !== 32'h0040000C) begin
            errs++; $display("FAIL pc_hold got=%h exp=%h", bus.PC, 32'h0040000C);
        end
    endtask

    task automatic test_x0();
        idle();
        bus.instr = 32'h00700013; bus.ALUSrc = 1; bus.ALUCtrl = 4'h2; bus.RegWrite = 1;
        step();
        show_reg(5'd0);
        vecs++;
        if (bus.dAddress !== 32'd0) begin
            errs++; $display("FAIL x0_write got=%h exp=0", bus.dAddress);
        end
        idle();
        bus.instr = enc_i(12'h123, 5'd0, 5'd31, 7'b0010011); bus.ALUSrc = 1; bus.ALUCtrl = 4'h2; bus.RegWrite = 1;
        step();
        show_reg(5'd31);
        vecs++;
        if (bus.dAddress !== 32'h123) begin
            errs++; $display("FAIL x31_write got=%h exp=%h", bus.dAddress, 32'h123);
        end
        // Reset with a write and a PC update in flight: both discarded.
        idle();
        bus.instr = enc_i(12'h055, 5'd0, 5'd31, 7'b0010011); bus.ALUSrc = 1; bus.ALUCtrl = 4'h2;
        bus.RegWrite = 1; bus.loadPC = 1;
        rst = 1;
        step();
        rst = 0;
        show_reg(5'd31);
        vecs++;
        if (bus.dAddress !== 32'd0) begin
            errs++; $display("FAIL rst_x31 got=%h exp=0", bus.dAddress);
        end
        vecs++;
        if (bus.PC !== 32'h00400000) begin
            errs++; $display("FAIL rst_pc got=%h exp=%h", bus.PC, 32'h00400000);
        end
    endtask

    task automatic test_random();
        logic [6:0] opcs [6];
        logic [3:0] ops [10];
        logic [31:0] exp_alu, exp_wb, exp_rs2;
        opcs = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h33, 7'h37};
        ops  = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h5, 4'h4, 4'h8, 4'h9, 4'hA, 4'hF};
        for (int n = 0; n < 300; n++) begin
            idle();
            bus.instr     = $urandom;
            bus.instr[6:0] = opcs[$urandom_range(0, 5)];
            bus.ALUSrc    = 1'($urandom);
            bus.ALUCtrl   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
            bus.RegWrite  = ($urandom_range(0, 3) != 0);
            bus.MemToReg  = ($urandom_range(0, 3) == 0);
            bus.dReadData = $urandom;
            bus.loadPC    = 1'($urandom);
            bus.PCSrc     = 1'($urandom);
            rst           = ($urandom_range(0, 40) == 0);
            #1;
            exp_alu = m_alu_now();
            exp_wb  = bus.MemToReg ? bus.dReadData : exp_alu;
            exp_rs2 = m_rd(bus.instr[24:20]);
            vecs++;
            if (bus.dAddress !== exp_alu) begin
                errs++; $display("FAIL rnd%0d_alu ins=%h op=%h got=%h exp=%h", n, bus.instr, bus.ALUCtrl, bus.dAddress, exp_alu);
            end
            vecs++;
            if (bus.Zero !== (exp_alu == 0)) begin
                errs++; $display("FAIL rnd%0d_zero got=%b exp=%b", n, bus.Zero, exp_alu == 0);
            end
            vecs++;
            if (bus.WriteBackData !== exp_wb) begin
                errs++; $display("FAIL rnd%0d_wb got=%h exp=%h", n, bus.WriteBackData, exp_wb);
            end
            vecs++;
            if (bus.dWriteData !== exp_rs2) begin
                errs++; $display("FAIL rnd%0d_rs2 got=%h exp=%h", n, bus.dWriteData, exp_rs2);
            end
            step();
            rst = 0;
            vecs++;
            if (bus.PC !== m_pc) begin
                errs++; $display("FAIL rnd%0d_pc got=%h exp=%h", n, bus.PC, m_pc);
            end
        end
        // Final sweep of the whole register file against the model.
        for (int r = 0; r < 32; r++) begin
            show_reg(r[4:0]);
            vecs++;
            if (bus.dAddress !== m_rd(r[4:0])) begin
                errs++; $display("FAIL sweep_x%0d got=%h exp=%h", r, bus.dAddress, m_rd(r[4:0]));
            end
        end
    endtask

    initial begin
        rst = 1;
        m_pc = 32'h00400000;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_sw_sub_sra();
        test_load();
        test_branch();
        test_x0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
